fdd_sd_arbiter: RTL and testbench
=================================

# fdd_sd_arbiter

Round-robin arbiter that shares one host SD block port among the four floppy drive units (USEL 0..3). It sits between the per-drive track loaders (per-drive `sd_lba`/`sd_rd`/`sd_wr` requests) and the single HPS block-access channel. It serialises block transfers, steers acknowledge and buffer traffic to the granted drive, and holds every other drive off until the current transfer completes.

## Interface
- `NUM_DRIVES`, 4: number of requesters; the width of every per-drive vector.
- `TIMEOUT_CYCLES`, 32'd50_000_000: number of cycles in ISSUE with no `sd_ack` before abort. Used only with the macro.
- `clk` in 1: system clock.
- `resetn` in 1: asynchronous, active-low reset.
- `req_lba[0:3]` in 32: block address from each drive.
- `req_blk_cnt[0:3]` in 6: blocks minus one, from each drive.
- `req_rd` in 4: per-drive read request (level).
- `req_wr` in 4: per-drive write request (level).
- `req_ack` out 4: per-drive acknowledge, equal to `sd_ack` on the granted bit.
- `req_buff_wr` out 4: `sd_buff_wr` gated to the granted drive.
- `req_buff_din[0:3]` in 8: write data from each drive's track buffer.
- `req_err` out 4: one-cycle abort pulse to the granted drive (macro only).
- `sd_lba` out 32: latched LBA of the granted request.
- `sd_blk_cnt` out 6: latched block count.
- `sd_rd` out 1: host read strobe.
- `sd_wr` out 1: host write strobe.
- `sd_ack` in 1: host acknowledge; high for the whole transfer.
- `sd_buff_wr` in 1: host buffer write strobe.
- `sd_buff_din` out 8: `req_buff_din[grant]`.
- `grant` out 4: one-hot granted drive; 0 when idle.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, ACTIVE, RELEASE.
- **IDLE**
  - Candidates are drives with `req_rd|req_wr`.
  - The search starts at `last+1` mod 4, where `last` is the index of the previously granted drive.
  - On a hit: latch `sd_lba`, `sd_blk_cnt` and direction; set `grant`; go to ISSUE.
  - If both `req_rd` and `req_wr` are set on the picked drive, write wins.
- **ISSUE**
  - Drive `sd_rd` or `sd_wr` high according to the latched direction.
  - On `sd_ack`=1: clear the strobe and go to ACTIVE.
  - Once latched, a request is committed. Withdrawal of `req_rd/req_wr` in ISSUE is ignored.
- **ACTIVE**
  - `req_ack`, `req_buff_wr` and `sd_buff_din` are routed to/from the granted drive.
  - On `sd_ack`=0: go to RELEASE.
- **RELEASE**
  - Lasts one cycle. Update `last` to the granted index, clear `grant`, go to IDLE.
  - The gap prevents re-granting a requester whose `req_rd` has not yet dropped.
- Non-granted `req_ack`, `req_buff_wr` and `req_err` are always 0.
- `sd_ack` seen in IDLE or RELEASE is ignored and not forwarded.
- Reset values: state IDLE, `last`=3 (so drive 0 is searched first), `grant`=0, `sd_rd`=`sd_wr`=0, `sd_lba`=0, `sd_blk_cnt`=0, `busy`=0, `req_err`=0.
- Reset asserted mid-transfer drops the strobes immediately. A later `sd_ack` is ignored until the next grant.

## Timing
- Request high before edge N: `grant` and the strobe are registered at edge N, so `sd_rd`/`sd_wr` are visible one cycle after the request.
- `sd_ack` rise at edge M: the strobe is low after M+1.
- The following paths are combinational, zero latency:
  - `req_ack`
  - `req_buff_wr`
  - `sd_buff_din`

  This is required so that host buffer writes and dual-port RAM reads stay aligned with `sd_buff_addr`.
- Minimum cycle: IDLE → ISSUE → ACTIVE → RELEASE → IDLE, so back-to-back grants are at least 4 cycles apart. The transfer length itself is set by the host.

## Configuration
- Macro: `FDD_SD_ARB_TIMEOUT_EN`.
- With the macro defined:
  - A 32-bit counter runs while in ISSUE.
  - When the count reaches `TIMEOUT_CYCLES`, drop the strobe and pulse `req_err[grant]` for one cycle.
  - Then go through RELEASE to IDLE.
  - The counter clears on entry to ISSUE.
- Without the macro: `req_err` is tied to 0 and the arbiter waits in ISSUE indefinitely.

## Structure
- Package `fdd_pkg`:
  - `fdd_arb_state_t` enum (IDLE/ISSUE/ACTIVE/RELEASE).
  - `FDD_NUM_DRIVES`=4.
  - `FDD_LBA_W`=32, `FDD_BLKCNT_W`=6.
- Sub-module `fdd_rr_pick`: combinational round-robin priority encoder.
  - Inputs: request vector, `last`.
  - Outputs: `hit` and 2-bit index.

## Test plan
- **Single request.** Drive 2 raises `req_rd` with `req_lba`=0x120, `req_blk_cnt`=8.
  - Next cycle: `grant`=4'b0100, `sd_rd`=1, `sd_lba`=0x120, `sd_blk_cnt`=8.
  - `sd_ack` high: `req_ack`=4'b0100 and `sd_rd`=0 the following cycle.
- **Round-robin.** Drives 0, 1 and 3 request simultaneously and continuously.
  - Grant order is 0, 1, 3, 0, …
  - No drive is granted twice in a row while others are pending.
- **Buffer steering.** During an ACTIVE write for drive 1, `req_buff_din[1]`=0xA5 and `req_buff_din[0]`=0x3C.
  - `sd_buff_din`=0xA5 in the same cycle.
  - A host `sd_buff_wr` pulse appears only on `req_buff_wr[1]`.
- **Read/write collision.** Drive 0 asserts `req_rd` and `req_wr` together → `sd_wr`=1 and `sd_rd`=0.
- **Reset in ACTIVE.** Pull `resetn` low while ACTIVE.
  - Asynchronously: `grant`=0 and `sd_rd`=`sd_wr`=0.
  - A following `sd_ack` produces no `req_ack`.
- **Timeout (macro on, `TIMEOUT_CYCLES`=16).** No `sd_ack` arrives.
  - `req_err[grant]` pulses once, 16 cycles after ISSUE entry.
  - `busy` falls 2 cycles later.

Source files
------------

// File: rtl/fdd_sd_arbiter_pkg.sv
// Shared types and constants for the floppy-drive SD block-port arbiter.
package fdd_pkg;

  localparam int unsigned FDD_NUM_DRIVES = 4;
  localparam int unsigned FDD_LBA_W      = 32;
  localparam int unsigned FDD_BLKCNT_W   = 6;
  localparam int unsigned FDD_IDX_W      = 2;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_ACTIVE  = 2'd2,
    ARB_RELEASE = 2'd3
  } fdd_arb_state_t;

endpackage

// File: rtl/fdd_sd_arbiter_if.sv
// Bundle of per-drive request lanes and the single host SD block channel.
interface fdd_sd_arbiter_if
  import fdd_pkg::*;
#(
  parameter int unsigned NUM_DRIVES = FDD_NUM_DRIVES
);

  logic [FDD_LBA_W-1:0]    req_lba     [0:NUM_DRIVES-1];
  logic [FDD_BLKCNT_W-1:0] req_blk_cnt [0:NUM_DRIVES-1];
  logic [NUM_DRIVES-1:0]   req_rd;
  logic [NUM_DRIVES-1:0]   req_wr;
  logic [NUM_DRIVES-1:0]   req_ack;
  logic [NUM_DRIVES-1:0]   req_buff_wr;
  logic [7:0]              req_buff_din [0:NUM_DRIVES-1];
  logic [NUM_DRIVES-1:0]   req_err;
  logic [FDD_LBA_W-1:0]    sd_lba;
  logic [FDD_BLKCNT_W-1:0] sd_blk_cnt;
  logic                    sd_rd;
  logic                    sd_wr;
  logic                    sd_ack;
  logic                    sd_buff_wr;
  logic [7:0]              sd_buff_din;
  logic [NUM_DRIVES-1:0]   grant;
  logic                    busy;

  // Arbiter side.
  modport slave (
    input  req_lba, req_blk_cnt, req_rd, req_wr, req_buff_din, sd_ack, sd_buff_wr,
    output req_ack, req_buff_wr, req_err, sd_lba, sd_blk_cnt, sd_rd, sd_wr,
           sd_buff_din, grant, busy
  );

  // Drives plus host side.
  modport master (
    output req_lba, req_blk_cnt, req_rd, req_wr, req_buff_din, sd_ack, sd_buff_wr,
    input  req_ack, req_buff_wr, req_err, sd_lba, sd_blk_cnt, sd_rd, sd_wr,
           sd_buff_din, grant, busy
  );

endinterface

// File: rtl/fdd_sd_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester after `last`.
module fdd_rr_pick
  import fdd_pkg::*;
(
  input  logic [FDD_NUM_DRIVES-1:0] req_i,
  input  logic [FDD_IDX_W-1:0]      last_i,
  output logic                      hit_o,
  output logic [FDD_IDX_W-1:0]      idx_o
);

  // Walk from farthest to nearest so the nearest candidate is the last one written.
  always_comb begin
    logic [FDD_IDX_W-1:0] cand;
    hit_o = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int unsigned i = FDD_NUM_DRIVES; i >= 1; i--) begin
      cand = last_i + i[FDD_IDX_W-1:0];
      if (req_i[cand]) begin
        hit_o = 1'b1;
        idx_o = cand;
      end
    end
  end

endmodule

// File: rtl/fdd_sd_arbiter.sv
// Round-robin sharing of the host SD block port among four floppy drives.
// Optional ISSUE-state timeout with per-drive abort pulse: FDD_SD_ARB_TIMEOUT_EN.
module fdd_sd_arbiter
  import fdd_pkg::*;
#(
  parameter int unsigned NUM_DRIVES     = FDD_NUM_DRIVES,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
)(
  input  logic             clk,
  input  logic             resetn,
  fdd_sd_arbiter_if.slave  bus
);

  fdd_arb_state_t          state_q, state_d;
  logic [FDD_IDX_W-1:0]    last_q,  last_d;
  logic [FDD_IDX_W-1:0]    gidx_q,  gidx_d;
  logic [NUM_DRIVES-1:0]   grant_q, grant_d;
  logic                    sd_rd_q, sd_rd_d;
  logic                    sd_wr_q, sd_wr_d;
  logic [FDD_LBA_W-1:0]    lba_q,   lba_d;
  logic [FDD_BLKCNT_W-1:0] blk_q,   blk_d;

  logic [NUM_DRIVES-1:0]   req_any;
  logic                    pick_hit;
  logic [FDD_IDX_W-1:0]    pick_idx;
  logic                    timeout;
  logic                    fwd;

  assign req_any = bus.req_rd | bus.req_wr;

  fdd_rr_pick u_pick (
    .req_i  (req_any),
    .last_i (last_q),
    .hit_o  (pick_hit),
    .idx_o  (pick_idx)
  );

`ifdef FDD_SD_ARB_TIMEOUT_EN
  logic [31:0] cnt_q;

  // Held at zero outside ISSUE, so it restarts on every ISSUE entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                  cnt_q <= '0;
    else if (state_q != ARB_ISSUE) cnt_q <= '0;
    else                          cnt_q <= cnt_q + 32'd1;
  end

  assign timeout = (state_q == ARB_ISSUE) && !bus.sd_ack && (cnt_q == TIMEOUT_CYCLES);
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    sd_rd_d = sd_rd_q;
    sd_wr_d = sd_wr_q;
    lba_d   = lba_q;
    blk_d   = blk_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_hit) begin
          lba_d             = bus.req_lba[pick_idx];
          blk_d             = bus.req_blk_cnt[pick_idx];
          gidx_d            = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          sd_wr_d           = bus.req_wr[pick_idx];
          sd_rd_d           = !bus.req_wr[pick_idx];
          state_d           = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        if (bus.sd_ack) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = ARB_ACTIVE;
        end else if (timeout) begin
          sd_rd_d = 1'b0;
          sd_wr_d = 1'b0;
          state_d = ARB_RELEASE;
        end
      end
      ARB_ACTIVE: begin
        if (!bus.sd_ack) state_d = ARB_RELEASE;
      end
      ARB_RELEASE: begin
        last_d  = gidx_q;
        grant_d = '0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      last_q  <= 2'd3;
      gidx_q  <= '0;
      grant_q <= '0;
      sd_rd_q <= 1'b0;
      sd_wr_q <= 1'b0;
      lba_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      sd_rd_q <= sd_rd_d;
      sd_wr_q <= sd_wr_d;
      lba_q   <= lba_d;
      blk_q   <= blk_d;
    end
  end

  // Host ack and buffer strobes only reach a drive while its transfer is live.
  assign fwd             = (state_q == ARB_ISSUE) || (state_q == ARB_ACTIVE);
  assign bus.req_ack     = (fwd && bus.sd_ack)     ? grant_q : '0;
  assign bus.req_buff_wr = (fwd && bus.sd_buff_wr) ? grant_q : '0;
  assign bus.req_err     = timeout ? grant_q : '0;
  assign bus.sd_buff_din = bus.req_buff_din[gidx_q];
  assign bus.sd_lba      = lba_q;
  assign bus.sd_blk_cnt  = blk_q;
  assign bus.sd_rd       = sd_rd_q;
  assign bus.sd_wr       = sd_wr_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_fdd_sd_arbiter.sv
// Directed bench for fdd_sd_arbiter; covers the timeout path when FDD_SD_ARB_TIMEOUT_EN is set.
module tb_fdd_sd_arbiter;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  fdd_sd_arbiter_if #(.NUM_DRIVES(4)) bus ();

  fdd_sd_arbiter #(
    .NUM_DRIVES     (4),
    .TIMEOUT_CYCLES (32'd16)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transfer from IDLE with requests already presented.
  task automatic xfer(input logic [3:0] exp_grant, input logic exp_rd, input logic exp_wr);
    step();
    chk("xfer_grant", bus.grant, exp_grant);
    chk("xfer_rd", bus.sd_rd, exp_rd);
    chk("xfer_wr", bus.sd_wr, exp_wr);
    bus.sd_ack = 1'b1;
    step();
    chk("xfer_strobe_off", {bus.sd_rd, bus.sd_wr}, 2'b00);
    bus.sd_ack = 1'b0;
    step();
    chk("xfer_release_busy", bus.busy, 1'b1);
    step();
    chk("xfer_idle_busy", bus.busy, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    bus.req_rd     = '0;
    bus.req_wr     = '0;
    bus.sd_ack     = 1'b0;
    bus.sd_buff_wr = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      bus.req_lba[i]      = 32'h1000 + 32'(i);
      bus.req_blk_cnt[i]  = 6'(i + 1);
      bus.req_buff_din[i] = 8'(8'h10 * i);
    end
    #12;
    chk("rst_grant", bus.grant, 4'b0000);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_strobes", {bus.sd_rd, bus.sd_wr}, 2'b00);
    chk("rst_lba", bus.sd_lba, 32'h0);
    chk("rst_blk", bus.sd_blk_cnt, 6'h0);
    chk("rst_err", bus.req_err, 4'b0000);
    resetn = 1'b1;
    step();
    chk("idle_busy", bus.busy, 1'b0);

    // Round-robin from reset: 0, 1, 3, 0.
    bus.req_rd = 4'b1011;
    xfer(4'b0001, 1'b1, 1'b0);
    xfer(4'b0010, 1'b1, 1'b0);
    xfer(4'b1000, 1'b1, 1'b0);
    xfer(4'b0001, 1'b1, 1'b0);
    bus.req_rd = '0;

    // Single read request from drive 2.
    bus.req_lba[2]     = 32'h120;
    bus.req_blk_cnt[2] = 6'd8;
    bus.req_rd         = 4'b0100;
    step();
    chk("single_grant", bus.grant, 4'b0100);
    chk("single_rd", bus.sd_rd, 1'b1);
    chk("single_wr", bus.sd_wr, 1'b0);
    chk("single_lba", bus.sd_lba, 32'h120);
    chk("single_blk", bus.sd_blk_cnt, 6'd8);
    chk("single_busy", bus.busy, 1'b1);
    chk("single_noack", bus.req_ack, 4'b0000);
    bus.req_rd = '0;
    step();
    chk("single_committed", bus.sd_rd, 1'b1);
    bus.sd_ack = 1'b1;
    #1;
    chk("single_req_ack", bus.req_ack, 4'b0100);
    step();
    chk("single_rd_off", bus.sd_rd, 1'b0);
    chk("single_ack_active", bus.req_ack, 4'b0100);
    bus.sd_ack = 1'b0;
    step();
    step();
    chk("single_done", bus.grant, 4'b0000);

    // Buffer steering on a drive 1 write (last=2, so 3,0,1 searched).
    bus.req_wr = 4'b0010;
    step();
    chk("steer_grant", bus.grant, 4'b0010);
    chk("steer_wr", bus.sd_wr, 1'b1);
    chk("steer_lba", bus.sd_lba, 32'h1001);
    bus.req_wr = '0;
    bus.sd_ack = 1'b1;
    step();
    bus.req_buff_din[1] = 8'hA5;
    bus.req_buff_din[0] = 8'h3C;
    #1;
    chk("steer_din", bus.sd_buff_din, 8'hA5);
    bus.sd_buff_wr = 1'b1;
    #1;
    chk("steer_buff_wr", bus.req_buff_wr, 4'b0010);
    bus.sd_buff_wr = 1'b0;
    #1;
    chk("steer_buff_wr_off", bus.req_buff_wr, 4'b0000);
    bus.sd_ack = 1'b0;
    step();
    bus.sd_ack = 1'b1;
    #1;
    chk("release_ack_ignored", bus.req_ack, 4'b0000);
    bus.sd_ack = 1'b0;
    step();

    // Read/write collision on drive 0: write wins.
    bus.req_rd = 4'b0001;
    bus.req_wr = 4'b0001;
    step();
    chk("coll_grant", bus.grant, 4'b0001);
    chk("coll_wr", bus.sd_wr, 1'b1);
    chk("coll_rd", bus.sd_rd, 1'b0);
    bus.req_rd = '0;
    bus.req_wr = '0;
    bus.sd_ack = 1'b1;
    step();
    chk("coll_active_ack", bus.req_ack, 4'b0001);

    // Asynchronous reset while ACTIVE.
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_grant", bus.grant, 4'b0000);
    chk("arst_strobes", {bus.sd_rd, bus.sd_wr}, 2'b00);
    chk("arst_busy", bus.busy, 1'b0);
    resetn = 1'b1;
    #1;
    chk("arst_ack_blocked", bus.req_ack, 4'b0000);
    step();
    chk("arst_ack_blocked2", bus.req_ack, 4'b0000);
    chk("arst_idle", bus.busy, 1'b0);
    bus.sd_ack = 1'b0;
    step();

`ifdef FDD_SD_ARB_TIMEOUT_EN
    // Drive 2 read, host never acknowledges.
    bus.req_rd = 4'b0100;
    step();
    chk("to_grant", bus.grant, 4'b0100);
    bus.req_rd = '0;
    for (int unsigned k = 1; k < 16; k++) begin
      step();
      chk("to_no_err", bus.req_err, 4'b0000);
    end
    step();
    chk("to_err", bus.req_err, 4'b0100);
    chk("to_busy_hold", bus.busy, 1'b1);
    step();
    chk("to_err_once", bus.req_err, 4'b0000);
    chk("to_strobe_off", bus.sd_rd, 1'b0);
    chk("to_busy_release", bus.busy, 1'b1);
    step();
    chk("to_busy_fall", bus.busy, 1'b0);
`else
    bus.req_rd = 4'b0100;
    for (int unsigned k = 0; k < 20; k++) step();
    chk("noto_waits", bus.sd_rd, 1'b1);
    chk("noto_err", bus.req_err, 4'b0000);
    bus.req_rd = '0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
